keyboard_fifo_input: RTL

Memory-mapped keyboard input peripheral for the didactic RISC-V core. It is the synthesizable successor of the file-fed keyboard reader.
- Key codes arrive on a valid/ready push interface from a PS/2 decoder or the bench, and are buffered in a parametrised FIFO.
- Each CPU read strobe pops one entry.
- A status word is returned on a tristated 32-bit bus shared with other I/O devices.
- An internal LFSR replaces simulation-only random generation.

---
 rtl/kbd_pkg.sv | 31 +++
 rtl/kbd_fifo.sv | 59 +++++
 rtl/keyboard_fifo_input.sv | 106 ++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kbd_pkg
// Purpose : Status-word field map, constants and packed view of the keyboard
//           peripheral's read word.
// Revision: 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam int KEY_MSB   = 31;
    localparam int KEY_LSB   = 24;
    localparam int EMPTY_BIT = 23;
    localparam int OVF_BIT   = 22;
    localparam int COUNT_MSB = 15;
    localparam int COUNT_LSB = 8;
    localparam int RAND_MSB  = 7;

    localparam logic [7:0]  EMPTY_KEY  = 8'hFF;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic [7:0] key;
        logic       empty;
        logic       ovf;
        logic [5:0] rsvd;
        logic [7:0] count;
        logic [7:0] rnd;
    } kbd_status_t;

endpackage
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : kbd_fifo
// Purpose : Generic synchronous FIFO with extra-MSB pointers, async reset and
//           a synchronous flush that overrides push and pop.
// Revision: 1.0 - initial release
// ============================================================================
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign count = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_push = push & ~full  & ~clear;
    assign w_do_pop  = pop  & ~empty & ~clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty masks whatever the head slot holds.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/keyboard_fifo_input.sv
`default_nettype none
// ============================================================================
// Module  : keyboard_fifo_input
// Purpose : Memory-mapped keyboard input: buffered key codes, status word on a
//           shared tristate bus, LFSR random byte. Optional irq: KBD_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
module keyboard_fifo_input
    import kbd_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          KEY_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [KEY_WIDTH-1:0] key_data,
    output logic                 key_ready,
    input  logic                 read,
    input  logic                 clear,
`ifdef KBD_IRQ_EN
    output logic                 irq,
`endif
    output logic [31:0]          data_out
);

    localparam int          c_AW   = $clog2(DEPTH);
    localparam logic [15:0] c_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [KEY_WIDTH-1:0] w_head;
    logic [c_AW:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [31:0]          w_word;
    kbd_status_t          w_status;
    logic                 r_overflow;
    logic [15:0]          r_lfsr;

    kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (key_valid),
        .pop     (read),
        .clear   (clear),
        .wr_data (key_data),
        .head    (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign key_ready = ~w_full;
    assign w_drop    = key_valid & w_full & ~clear;

    always_comb begin
        w_word                          = '0;
        w_word[KEY_MSB:KEY_LSB]         = w_empty ? EMPTY_KEY : 8'(w_head);
        w_word[EMPTY_BIT]               = w_empty;
        w_word[OVF_BIT]                 = r_overflow;
        w_word[COUNT_MSB:COUNT_LSB]     = 8'(w_count);
        w_word[RAND_MSB:0]              = r_lfsr[7:0];
    end

    assign w_status = w_word;
    assign data_out = read ? w_word : 32'hzzzz_zzzz;

    // A drop in the same cycle as the clearing read keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (read && w_status.ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= c_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

`ifdef KBD_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (clear) begin
            irq <= 1'b0;
        end else begin
            irq <= ~w_empty | r_overflow;
        end
    end
`endif

endmodule
`default_nettype wire
